// File: rtl/picorv32_pcpi_pkg.sv
// -----------------------------------------------------------------------------
// picorv32_pcpi_pkg
// Shared types and constants for the PicoRV32 PCPI hub and its coprocessors.
//   - hub_state_e    : hub FSM state encoding
//   - pcpi_req_t     : captured request (insn + two operands)
//   - pcpi_rsp_t     : one coprocessor response (write-enable + result)
//   - TIMEOUT_CYC_DEF: default claim window of the hub watchdog
//   - PCPI_OPC_OP / PCPI_F7_MULDIV: RV32M encoding fields, used by
//     coprocessors and benches (the hub itself never decodes instructions)
// -----------------------------------------------------------------------------
package picorv32_pcpi_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  localparam logic [6:0] PCPI_OPC_OP    = 7'b0110011;
  localparam logic [6:0] PCPI_F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } hub_state_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } pcpi_req_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
  } pcpi_rsp_t;

  // Builds an RV32M R-type instruction word (MUL* for funct3 0..3, DIV*/REM*
  // for funct3 4..7).
  function automatic logic [31:0] muldiv_insn(input logic [2:0] funct3,
                                              input logic [4:0] rd,
                                              input logic [4:0] rs1,
                                              input logic [4:0] rs2);
    return {PCPI_F7_MULDIV, rs2, rs1, funct3, rd, PCPI_OPC_OP};
  endfunction

endpackage

// File: rtl/picorv32_pcpi_hub_if.sv
// -----------------------------------------------------------------------------
// picorv32_pcpi_hub_if
// All PCPI traffic around the hub bundled in one interface:
//   pcpi_* : core request (valid/insn/rs1/rs2) and core response
//            (wr/rd/wait/ready) plus the pcpi_timeout pulse
//   slv_*  : request broadcast to both coprocessors
//   mul_*  : multiplier response (wr/rd/wait/ready)
//   div_*  : divider response (wr/rd/wait/ready)
//   err_multi : sticky "both coprocessors claimed the same instruction"
// Modports:
//   slave  : the hub's view (it serves the core and drives the broadcast)
//   master : the environment's view (core plus coprocessors)
// -----------------------------------------------------------------------------
interface picorv32_pcpi_hub_if;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;

  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        pcpi_timeout;

  logic        slv_valid;
  logic [31:0] slv_insn;
  logic [31:0] slv_rs1;
  logic [31:0] slv_rs2;

  logic        mul_wr;
  logic [31:0] mul_rd;
  logic        mul_wait;
  logic        mul_ready;

  logic        div_wr;
  logic [31:0] div_rd;
  logic        div_wait;
  logic        div_ready;

  logic        err_multi;

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  mul_wr, mul_rd, mul_wait, mul_ready,
    input  div_wr, div_rd, div_wait, div_ready,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    output slv_valid, slv_insn, slv_rs1, slv_rs2,
    output err_multi
  );

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output mul_wr, mul_rd, mul_wait, mul_ready,
    output div_wr, div_rd, div_wait, div_ready,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, pcpi_timeout,
    input  slv_valid, slv_insn, slv_rs1, slv_rs2,
    input  err_multi
  );

endinterface

// File: rtl/picorv32_pcpi_wdog.sv
// -----------------------------------------------------------------------------
// picorv32_pcpi_wdog
// Claim watchdog for the PCPI hub.
//   clk, reset : clock and synchronous active-high reset
//   clear      : new request accepted, restart the count from 0
//   active     : hub is broadcasting (ISSUE)
//   hold       : some coprocessor is asserting wait (it has claimed the insn)
//   expired    : TIMEOUT_CYC unclaimed cycles have elapsed
// The count advances once per active cycle without wait, is forced to 0
// while any wait is high, and saturates at the limit.
// -----------------------------------------------------------------------------
module picorv32_pcpi_wdog #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  input  logic hold,
  output logic expired
);

  // Largest legal TIMEOUT_CYC is 255, so 8 bits always suffice.
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // A claimed instruction (wait high) can never expire.
  assign expired = active && !hold && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (active) begin
      if (hold) begin
        cnt_d = '0;
      end else if (cnt_q != LIMIT) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/picorv32_pcpi_hub.sv
// -----------------------------------------------------------------------------
// picorv32_pcpi_hub
// Fans one PicoRV32 PCPI port out to a multiplier and a divider coprocessor.
// Every request is broadcast to both; whichever answers first with ready is
// forwarded to the core. A request nobody claims within TIMEOUT_CYC cycles
// gets a one-cycle pcpi_timeout pulse instead of pcpi_ready.
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : picorv32_pcpi_hub_if.slave (core request/response, coprocessor
//           broadcast and responses, err_multi)
// Flow: IDLE -> ISSUE (broadcast, pcpi_wait high) -> RESP (ready or timeout
// pulse) -> DRAIN (wait for the core to drop pcpi_valid) -> IDLE.
// Dropping pcpi_valid during ISSUE abandons the request silently.
// -----------------------------------------------------------------------------
module picorv32_pcpi_hub
  import picorv32_pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  picorv32_pcpi_hub_if.slave    bus
);

  hub_state_e  state_q, state_d;
  pcpi_req_t   req_q, req_d;
  logic        pcpi_wr_q, pcpi_wr_d;
  logic [31:0] pcpi_rd_q, pcpi_rd_d;
  logic        pcpi_ready_q, pcpi_ready_d;
  logic        pcpi_timeout_q, pcpi_timeout_d;
  logic        err_multi_q, err_multi_d;

  logic        in_issue;
  logic        any_ready;
  logic        both_ready;
  logic        wdog_clear;
  logic        wdog_expired;
  pcpi_rsp_t   sel_rsp;

  assign in_issue   = (state_q == ST_ISSUE);
  assign any_ready  = bus.mul_ready | bus.div_ready;
  assign both_ready = bus.mul_ready & bus.div_ready;

  picorv32_pcpi_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wdog_clear),
    .active  (in_issue),
    .hold    (bus.mul_wait | bus.div_wait),
    .expired (wdog_expired)
  );

  // Multiplier has priority when both claim in the same cycle.
  always_comb begin
    sel_rsp.wr = bus.div_wr;
    sel_rsp.rd = bus.div_rd;
    if (bus.mul_ready) begin
      sel_rsp.wr = bus.mul_wr;
      sel_rsp.rd = bus.mul_rd;
    end
  end

  // NOTE: every signal driven here is given a default before the case so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    pcpi_wr_d      = 1'b0;
    pcpi_rd_d      = pcpi_rd_q;
    pcpi_ready_d   = 1'b0;
    pcpi_timeout_d = 1'b0;
    err_multi_d    = err_multi_q;
    wdog_clear     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.pcpi_valid) begin
          req_d.insn = bus.pcpi_insn;
          req_d.rs1  = bus.pcpi_rs1;
          req_d.rs2  = bus.pcpi_rs2;
          wdog_clear = 1'b1;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (both_ready) begin
          err_multi_d = 1'b1;
        end
        // A core abort (trap/IRQ) outranks any response arriving with it.
        if (!bus.pcpi_valid) begin
          state_d = ST_IDLE;
        end else if (any_ready) begin
          pcpi_ready_d = 1'b1;
          pcpi_wr_d    = sel_rsp.wr;
          pcpi_rd_d    = sel_rsp.rd;
          state_d      = ST_RESP;
        end else if (wdog_expired) begin
          pcpi_timeout_d = 1'b1;
          state_d        = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_DRAIN;
      end

      // The core still holds the retiring instruction on pcpi_valid; wait
      // for it to go away so the same instruction is not issued twice.
      ST_DRAIN: begin
        if (!bus.pcpi_valid) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order; reset is synchronous
  // and checked first so it also wins mid-transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      pcpi_wr_q      <= 1'b0;
      pcpi_rd_q      <= '0;
      pcpi_ready_q   <= 1'b0;
      pcpi_timeout_q <= 1'b0;
      err_multi_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      pcpi_wr_q      <= pcpi_wr_d;
      pcpi_rd_q      <= pcpi_rd_d;
      pcpi_ready_q   <= pcpi_ready_d;
      pcpi_timeout_q <= pcpi_timeout_d;
      err_multi_q    <= err_multi_d;
    end
  end

  // wait/valid are pure state decodes; everything else comes straight from
  // a flop.
  assign bus.pcpi_wait    = in_issue;
  assign bus.slv_valid    = in_issue;
  assign bus.slv_insn     = req_q.insn;
  assign bus.slv_rs1      = req_q.rs1;
  assign bus.slv_rs2      = req_q.rs2;
  assign bus.pcpi_wr      = pcpi_wr_q;
  assign bus.pcpi_rd      = pcpi_rd_q;
  assign bus.pcpi_ready   = pcpi_ready_q;
  assign bus.pcpi_timeout = pcpi_timeout_q;
  assign bus.err_multi    = err_multi_q;

endmodule

// File: tb/tb_picorv32_pcpi_hub.sv
// -----------------------------------------------------------------------------
// tb_picorv32_pcpi_hub
// Directed scenarios followed by randomized transactions. For each request
// the bench decides up front, from the hub's timing rules, which cycle the
// outcome lands in (ready or timeout), what result the core should see and
// whether err_multi must be set, then checks the hub cycle by cycle.
// Cycle numbering: cycle 0 is the first slv_valid cycle.
// -----------------------------------------------------------------------------
module tb_picorv32_pcpi_hub;
  import picorv32_pcpi_pkg::*;

  localparam int T = 16;

  typedef enum int {SRC_MUL, SRC_DIV, SRC_BOTH, SRC_NONE} src_e;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  picorv32_pcpi_hub_if bus ();

  picorv32_pcpi_hub #(
    .TIMEOUT_CYC (T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd;
  logic        err_exp;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic slaves_quiet();
    bus.mul_wr = 1'b0; bus.mul_rd = '0; bus.mul_wait = 1'b0; bus.mul_ready = 1'b0;
    bus.div_wr = 1'b0; bus.div_rd = '0; bus.div_wait = 1'b0; bus.div_ready = 1'b0;
  endtask

  // Random slave chatter, used only when the hub is not in ISSUE.
  task automatic slaves_garbage();
    bus.mul_wr    = 1'($urandom_range(0, 1));
    bus.mul_rd    = $urandom;
    bus.mul_wait  = 1'($urandom_range(0, 1));
    bus.mul_ready = 1'($urandom_range(0, 1));
    bus.div_wr    = 1'($urandom_range(0, 1));
    bus.div_rd    = $urandom;
    bus.div_wait  = 1'($urandom_range(0, 1));
    bus.div_ready = 1'($urandom_range(0, 1));
  endtask

  // Slave behaviour for ISSUE cycle j: wait during cycles 0..w-1, ready at k.
  task automatic drive_slaves(input src_e src, input int j, input int w,
                              input int k, input logic wr,
                              input logic [31:0] mul_val,
                              input logic [31:0] div_val);
    bit use_mul;
    bit use_div;
    use_mul = (src == SRC_MUL) || (src == SRC_BOTH);
    use_div = (src == SRC_DIV) || (src == SRC_BOTH);
    bus.mul_wait  = use_mul && (j < w);
    bus.mul_ready = use_mul && (j == k);
    bus.mul_wr    = use_mul && (j == k) && wr;
    bus.mul_rd    = (use_mul && (j == k)) ? mul_val : 32'h0;
    bus.div_wait  = (use_div || (src == SRC_NONE)) && (j < w);
    bus.div_ready = use_div && (j == k);
    bus.div_wr    = use_div && (j == k) && wr;
    bus.div_rd    = (use_div && (j == k)) ? div_val : 32'h0;
  endtask

  // One full request: issue, outcome, h extra DRAIN cycles, back to IDLE.
  task automatic run_txn(input string name, input src_e src,
                         input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input int w, input int k,
                         input logic wr, input logic [31:0] mul_val,
                         input logic [31:0] div_val, input int h);
    int          deadline;
    int          e;
    bit          responds;
    logic [31:0] exp_rd;
    logic        exp_wr;

    // Reference: the claim window restarts after the last wait cycle, so
    // an unclaimed request expires T cycles after it; a ready on or before
    // that cycle wins and shows up one cycle later.
    deadline = w + T;
    responds = (src != SRC_NONE) && (k <= deadline);
    e        = responds ? k + 1 : deadline + 1;
    if (responds) begin
      exp_rd = (src == SRC_DIV) ? div_val : mul_val;
      exp_wr = wr;
      if (src == SRC_BOTH) err_exp = 1'b1;
    end else begin
      exp_rd = last_rd;
      exp_wr = 1'b0;
    end

    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = rs2;
    slaves_garbage();

    @(posedge clk); #1;
    check({name, "/slv_insn"}, bus.slv_insn, insn);
    check({name, "/slv_rs1"}, bus.slv_rs1, rs1);
    check({name, "/slv_rs2"}, bus.slv_rs2, rs2);
    for (int j = 0; j < e; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      check({name, "/issue"},
            {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout},
            4'b1100);
      drive_slaves(src, j, w, k, wr, mul_val, div_val);
    end

    @(posedge clk); #1;
    check({name, "/outcome"},
          {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout,
           bus.pcpi_wr},
          {1'b0, 1'b0, responds, !responds, exp_wr});
    check({name, "/rd"}, bus.pcpi_rd, exp_rd);
    check({name, "/err_multi"}, 32'(bus.err_multi), 32'(err_exp));
    last_rd = exp_rd;
    slaves_garbage();

    for (int j = 0; j <= h; j++) begin
      @(posedge clk); #1;
      check({name, "/drain"},
            {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout,
             bus.pcpi_wr, bus.err_multi},
            {5'b00000, err_exp});
      check({name, "/rd_hold"}, bus.pcpi_rd, last_rd);
      slaves_garbage();
      if (j == h) bus.pcpi_valid = 1'b0;
    end

    @(posedge clk); #1;
    check({name, "/idle"},
          {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout,
           bus.pcpi_wr},
          5'b00000);
    slaves_quiet();
  endtask

  // Core abandons a divide that the divider is still working on.
  task automatic run_abort(input string name, input logic [31:0] insn,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input int a);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = rs2;
    slaves_quiet();
    @(posedge clk); #1;
    for (int j = 0; j <= a; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end
      check({name, "/issue"},
            {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout},
            4'b1100);
      bus.div_wait = 1'b1;
      if (j == a) bus.pcpi_valid = 1'b0;
    end
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check({name, "/dropped"},
            {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout,
             bus.pcpi_wr},
            5'b00000);
      check({name, "/rd_hold"}, bus.pcpi_rd, last_rd);
      // A late answer from the divider must be ignored.
      bus.div_wait  = 1'b0;
      bus.div_ready = 1'b1;
      bus.div_wr    = 1'b1;
      bus.div_rd    = 32'hBAD0_0000 | 32'(j);
    end
    slaves_quiet();
  endtask

  // Reset asserted while the hub is broadcasting.
  task automatic run_reset_mid(input string name);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = 32'h0220C1B3;
    bus.pcpi_rs1   = 32'd55;
    bus.pcpi_rs2   = 32'd5;
    slaves_quiet();
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      check({name, "/issue"},
            {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout},
            4'b1100);
      bus.div_wait = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check({name, "/flags"},
          {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout,
           bus.pcpi_wr, bus.err_multi},
          6'b000000);
    check({name, "/pcpi_rd"}, bus.pcpi_rd, 32'h0);
    check({name, "/slv_insn"}, bus.slv_insn, 32'h0);
    check({name, "/slv_rs1"}, bus.slv_rs1, 32'h0);
    check({name, "/slv_rs2"}, bus.slv_rs2, 32'h0);
    reset          = 1'b0;
    bus.pcpi_valid = 1'b0;
    err_exp        = 1'b0;
    last_rd        = 32'h0;
    slaves_quiet();
    @(posedge clk); #1;
  endtask

  initial begin
    src_e        src;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] insn;
    logic [31:0] mul_val;
    logic [31:0] div_val;
    int          w;
    int          k;
    logic        wr;

    reset          = 1'b1;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = '0;
    bus.pcpi_rs1   = '0;
    bus.pcpi_rs2   = '0;
    slaves_quiet();
    last_rd = 32'h0;
    err_exp = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset/flags",
          {bus.slv_valid, bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_timeout,
           bus.pcpi_wr, bus.err_multi},
          6'b000000);
    check("reset/pcpi_rd", bus.pcpi_rd, 32'h0);
    check("reset/slv_insn", bus.slv_insn, 32'h0);
    check("reset/slv_rs1", bus.slv_rs1, 32'h0);
    check("reset/slv_rs2", bus.slv_rs2, 32'h0);
    reset = 1'b0;

    // DIV 100/7 with a 2-cycle wait, answer at cycle 4.
    run_txn("div", SRC_DIV, 32'h0220C1B3, 32'd100, 32'd7, 2, 4, 1'b1,
            32'hDEAD_BEEF, 32'd14, 1);
    // MUL 6*7 answering 3 cycles in.
    run_txn("mul", SRC_MUL, 32'h022081B3, 32'd6, 32'd7, 0, 3, 1'b1,
            32'd42, 32'h0, 0);
    // Custom-0 opcode: nobody claims it.
    run_txn("timeout", SRC_NONE, 32'h0000000B, 32'h11, 32'h22, 0, 0, 1'b0,
            32'h0, 32'h0, 2);
    // Wait for 3 cycles, then silence: window restarts after the waits.
    run_txn("timeout_wait", SRC_NONE, 32'h0000000B, 32'h33, 32'h44, 3, 0,
            1'b0, 32'h0, 32'h0, 0);
    // Ready in the very cycle the window expires.
    run_txn("ready_at_expiry", SRC_MUL, 32'h022081B3, 32'd9, 32'd9, 0, T,
            1'b1, 32'd81, 32'h0, 0);
    // Both claim at once: multiplier wins, err_multi latches.
    run_txn("both", SRC_BOTH, 32'h022081B3, 32'd1, 32'd2, 0, 2, 1'b1,
            32'd5, 32'd9, 1);
    run_txn("mul_after_both", SRC_MUL, 32'h022081B3, 32'd3, 32'd4, 1, 1,
            1'b1, 32'd12, 32'h0, 0);
    run_abort("abort", 32'h0220C1B3, 32'd100, 32'd7, 10);
    run_txn("after_abort", SRC_DIV, 32'h0220C1B3, 32'd100, 32'd7, 0, 2,
            1'b1, 32'h0, 32'd14, 0);
    run_reset_mid("reset_mid");
    run_txn("after_reset", SRC_MUL, 32'h022081B3, 32'd6, 32'd7, 0, 3, 1'b1,
            32'd42, 32'h0, 0);

    for (int n = 0; n < 40; n++) begin
      src = src_e'($urandom_range(0, 3));
      rs1 = $urandom;
      rs2 = 32'($urandom_range(1, 1000));
      case (src)
        SRC_MUL: insn = muldiv_insn(3'd0, 5'($urandom_range(1, 31)),
                                    5'($urandom_range(0, 31)),
                                    5'($urandom_range(0, 31)));
        SRC_DIV: insn = muldiv_insn(3'd4, 5'($urandom_range(1, 31)),
                                    5'($urandom_range(0, 31)),
                                    5'($urandom_range(0, 31)));
        SRC_BOTH: insn = muldiv_insn(3'($urandom_range(0, 7)), 5'd1, 5'd2, 5'd3);
        default: insn = {$urandom_range(0, 32'h1FF_FFFF), 7'b0001011};
      endcase
      w       = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      k       = w + int'($urandom_range(0, T + 3));
      wr      = ($urandom_range(0, 3) != 0);
      mul_val = (src == SRC_BOTH) ? $urandom : rs1 * rs2;
      div_val = (src == SRC_BOTH) ? $urandom : rs1 / rs2;
      run_txn($sformatf("rand%0d", n), src, insn, rs1, rs2, w, k, wr,
              mul_val, div_val, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/picorv32_pcpi_hub.md
PICORV32_PCPI_HUB -- requirements
Module: picorv32_pcpi_hub

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, legal range 4..255: cycles in ISSUE with no slave wait/ready before timeout.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports pcpi_valid / pcpi_insn / pcpi_rs1 / pcpi_rs2  input  1/32/32/32  request from core.
REQ-005 SHALL have ports pcpi_wr / pcpi_rd / pcpi_wait / pcpi_ready  output  1/32/1/1  response to core.
REQ-006 SHALL have port pcpi_timeout  output  1  one-cycle pulse: no coprocessor claimed the instruction.
REQ-007 SHALL have ports slv_valid / slv_insn / slv_rs1 / slv_rs2  output  1/32/32/32  request broadcast to both coprocessors.
REQ-008 SHALL have ports mul_wr, mul_rd, mul_wait, mul_ready and div_wr, div_rd, div_wait, div_ready  input  1/32/1/1 each  coprocessor responses.
REQ-009 SHALL have port err_multi  output  1  sticky flag: both coprocessors asserted ready in the same cycle.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, RESP, DRAIN.
REQ-011 IDLE: on pcpi_valid=1, SHALL capture insn/rs1/rs2 into slv_* registers, clear timeout counter, go to ISSUE.
REQ-012 ISSUE: slv_valid SHALL be 1; first slv_valid cycle is one cycle after the core's valid cycle.
REQ-013 ISSUE: pcpi_wait SHALL be 1 (decoded from state register), 0 in all other states.
REQ-014 ISSUE: counter SHALL increment each cycle with mul_wait=div_wait=0, and SHALL hold at 0 while either wait is 1.
REQ-015 ISSUE: on mul_ready or div_ready, SHALL register that slave's wr/rd into pcpi_wr/pcpi_rd, pulse pcpi_ready for one cycle (cycle after slave ready), go to RESP.
REQ-016 Both readys in same cycle: mul response SHALL win; err_multi SHALL set and stay 1 until reset.
REQ-017 ISSUE: counter reaching TIMEOUT_CYC with no ready SHALL pulse pcpi_timeout one cycle, with pcpi_ready=0 and pcpi_wr=0, go to RESP.
REQ-018 Ready and counter expiry in same cycle: ready SHALL win; no timeout pulse.
REQ-019 ISSUE: pcpi_valid=0 (core abort/trap) SHALL drop slv_valid next cycle, go to IDLE, without pcpi_ready or pcpi_timeout.
REQ-020 RESP: slv_valid SHALL be 0; pcpi_ready/pcpi_wr/pcpi_timeout SHALL return to 0; always go to DRAIN next cycle.
REQ-021 DRAIN: SHALL stay until pcpi_valid=0, then go to IDLE. This prevents re-issuing a retiring instruction.
REQ-022 pcpi_rd SHALL hold last captured value outside pulses; pcpi_wr SHALL be 1 only in the pcpi_ready cycle.
REQ-023 Slave responses arriving outside ISSUE SHALL be ignored.
REQ-024 No instruction decode SHALL occur in the hub: every request is broadcast and unclaimed ones time out.

Reset
REQ-025 reset=1 SHALL force state IDLE, counter 0, err_multi 0 at the next edge, including mid-ISSUE.
REQ-026 Reset values SHALL be: pcpi_wr, pcpi_wait, pcpi_ready, pcpi_timeout, slv_valid all 0; pcpi_rd and slv_insn/slv_rs1/slv_rs2 all 32'h0.
REQ-027 First request after reset release SHALL be accepted from IDLE with normal latency.

Structure
REQ-028 Package picorv32_pcpi_pkg SHALL hold: state enum type, TIMEOUT_CYC default, and constants PCPI_OPC_OP=7'b0110011 and PCPI_F7_MULDIV=7'b0000001 for benches/coprocessors.
REQ-029 Timeout counter (clear/hold/increment/expire) SHALL be one sub-module, picorv32_pcpi_wdog; response select stays in the hub.
REQ-030 All outputs SHALL be registered except pcpi_wait and slv_valid, which SHALL be decoded from the state register only.

Verification
REQ-031 DIV insn 0x0220C1B3, rs1=100, rs2=7, div model -> pcpi_rd=14, pcpi_wr=1 on single pcpi_ready pulse, pcpi_timeout=0.
REQ-032 MUL insn 0x022081B3, rs1=6, rs2=7, mul model ready after 3 cycles -> pcpi_rd=42, pcpi_ready exactly 1 cycle after mul_ready.
REQ-033 Insn 0x0000000B, no slave response -> pcpi_timeout pulse TIMEOUT_CYC+1 cycles after first slv_valid; pcpi_ready=0.
REQ-034 Forced mul_ready=div_ready=1, mul_rd=5, div_rd=9 same cycle -> pcpi_rd=5, err_multi=1 held until reset.
REQ-035 pcpi_valid dropped 10 cycles into a DIV (div_wait=1) -> slv_valid=0 next cycle, no pcpi_ready; next request served normally.
REQ-036 reset pulsed mid-ISSUE -> all outputs at reset values next cycle; err_multi cleared.
